// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer: holds the cpu in reset, streams a length-prefixed program into the
// instruction ROM from address 0, then releases the cpu and counts run cycles.
module cpu_boot_ctrl #(
  parameter int unsigned DW     = 16,
  parameter int unsigned PW     = 14,
  parameter int unsigned TO_CYC = 1024
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          stop_req,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          rom_we,
  output logic [PW-1:0] rom_addr,
  output logic [DW-1:0] rom_wdata,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   run_cycles
);

  // Index is one bit wider than the ROM address so a full-capacity load can be counted.
  localparam int unsigned IW      = PW + 1;
  localparam int unsigned CAP     = 32'd1 << PW;
  localparam int unsigned TW      = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  localparam int unsigned TO_LAST = (TO_CYC == 0) ? 0 : TO_CYC - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_DRAIN,
    ST_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            s_ready_q, s_ready_d;
  logic            rom_we_q, rom_we_d;
  logic [PW-1:0]   rom_addr_q, rom_addr_d;
  logic [DW-1:0]   rom_wdata_q, rom_wdata_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     run_cycles_q, run_cycles_d;
  logic            xfer;
  logic            timeout_hit;

  assign xfer        = s_valid && s_ready_q;
  assign timeout_hit = (TO_CYC != 0) && !xfer && (idle_cnt_q == TW'(TO_LAST));

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    idle_cnt_d   = idle_cnt_q;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_wdata_d  = rom_wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d      = ST_LEN;
          done_d       = 1'b0;
          err_d        = 1'b0;
          run_cycles_d = 32'd0;
          idle_cnt_d   = TW'(0);
        end
      end
      ST_LEN: begin
        if (xfer) begin
          idle_cnt_d = TW'(0);
          if (s_data == '0 || 32'(s_data) > CAP) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            len_d   = IW'(s_data);
            idx_d   = IW'(0);
            state_d = ST_LOAD;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          idle_cnt_d  = TW'(0);
          rom_we_d    = 1'b1;
          rom_addr_d  = PW'(idx_q);
          rom_wdata_d = s_data;
          idx_d       = idx_q + IW'(1);
          if (idx_q + IW'(1) == len_q) state_d = ST_DRAIN;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
      end
      ST_DRAIN: state_d = ST_RUN;
      ST_RUN: begin
        if (run_cycles_q != 32'hFFFF_FFFF) run_cycles_d = run_cycles_q + 32'd1;
        // A simultaneous reload request takes priority over stop.
        if (load_start) begin
          state_d      = ST_LEN;
          done_d       = 1'b0;
          err_d        = 1'b0;
          run_cycles_d = 32'd0;
          idle_cnt_d   = TW'(0);
        end else if (stop_req) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d   = (state_d == ST_LEN) || (state_d == ST_LOAD);
    busy_d      = (state_d == ST_LEN) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    cpu_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      idle_cnt_q   <= '0;
      s_ready_q    <= 1'b0;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_wdata_q  <= '0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      run_cycles_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      idle_cnt_q   <= idle_cnt_d;
      s_ready_q    <= s_ready_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_wdata_q  <= rom_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_wdata  = rom_wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign run_cycles = run_cycles_q;

endmodule
